// File: rtl/serial_frame_tx.sv
// serial_frame_tx: buffered start-bit, MSB-first serial transmitter
// with divided line clock, ready/valid FIFO input and status flags.
module serial_frame_tx #(
  parameter int CLK_DIV    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_BITS   = 1
) (
  input  logic                        Clk,
  input  logic                        nRst,
  input  logic [7:0]                  InData,
  input  logic                        InValid,
  output logic                        InReady,
  output logic                        SoClk,
  output logic                        SDout,
  output logic                        Busy,
  output logic                        FrameDone,
  output logic [$clog2(FIFO_DEPTH):0] Level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam int GAP_LAST = (GAP_BITS > 0) ? GAP_BITS - 1 : 0;

  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(GAP_LAST);
  localparam logic [LW-1:0] FULL    = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_GAP
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic            soclk_q, soclk_d;
  logic            sdout_q, sdout_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [GW-1:0]   gapcnt_q, gapcnt_d;
  logic            fdone_q, fdone_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [7:0]      mem [FIFO_DEPTH];

  logic wrap;
  logic fall_tick;
  logic push;
  logic pop;
  logic empty;
  logic launch;

  // Line clock divider
  always_comb begin
    wrap      = (div_q == DIV_MAX);
    div_d     = wrap ? '0 : div_q + DW'(1);
    soclk_d   = soclk_q ^ wrap;
    fall_tick = wrap & soclk_q;
  end

  assign InReady = (level_q != FULL);
  assign empty   = (level_q == '0);
  assign push    = InValid & InReady;

  always_comb begin
    wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + AW'(1) : rptr_q;
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      mem[wptr_q] <= InData;
    end
  end

  // Line FSM; only moves on the SoClk falling tick
  always_comb begin
    state_d  = state_q;
    sdout_d  = sdout_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    gapcnt_d = gapcnt_q;
    fdone_d  = 1'b0;
    pop      = 1'b0;
    launch   = 1'b0;
    if (fall_tick) begin
      unique case (state_q)
        S_IDLE: begin
          launch = 1'b1;
        end
        S_START: begin
          sdout_d  = shreg_q[7];
          shreg_d  = {shreg_q[6:0], 1'b0};
          bitcnt_d = '0;
          state_d  = S_DATA;
        end
        S_DATA: begin
          if (bitcnt_q != 3'd7) begin
            sdout_d  = shreg_q[7];
            shreg_d  = {shreg_q[6:0], 1'b0};
            bitcnt_d = bitcnt_q + 3'd1;
          end else begin
            fdone_d = 1'b1;
            if (GAP_BITS > 0) begin
              sdout_d  = 1'b0;
              gapcnt_d = '0;
              state_d  = S_GAP;
            end else begin
              launch = 1'b1;
            end
          end
        end
        S_GAP: begin
          if (gapcnt_q == GAP_MAX) begin
            launch = 1'b1;
          end else begin
            gapcnt_d = gapcnt_q + GW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          sdout_d = 1'b0;
        end
      endcase
      // Shared end-of-slot decision: start next frame or go idle
      if (launch) begin
        if (!empty) begin
          pop     = 1'b1;
          shreg_d = mem[rptr_q];
          sdout_d = 1'b1;
          state_d = S_START;
        end else begin
          sdout_d = 1'b0;
          state_d = S_IDLE;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      soclk_q  <= 1'b0;
      sdout_q  <= 1'b0;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      gapcnt_q <= '0;
      fdone_q  <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      soclk_q  <= soclk_d;
      sdout_q  <= sdout_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      gapcnt_q <= gapcnt_d;
      fdone_q  <= fdone_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
    end
  end

  assign SoClk     = soclk_q;
  assign SDout     = sdout_q;
  assign FrameDone = fdone_q;
  assign Level     = level_q;
  assign Busy      = (state_q != S_IDLE) | ~empty;

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: line-level model plus directed frames,
// loopback receiver, FIFO full behaviour, gapless mode and mid-frame reset.
module tb_serial_frame_tx;

  localparam int DIV   = 2;
  localparam int DEPTH = 4;
  localparam int GAP   = 1;

  logic       Clk = 1'b0;
  logic       nRst = 1'b1;
  logic [7:0] InData_a = '0;
  logic       InValid_a = 1'b0;
  logic       InReady_a, SoClk_a, SDout_a, Busy_a, FrameDone_a;
  logic [2:0] Level_a;
  logic [7:0] InData_b = '0;
  logic       InValid_b = 1'b0;
  logic       InReady_b, SoClk_b, SDout_b, Busy_b, FrameDone_b;
  logic [2:0] Level_b;

  serial_frame_tx #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH), .GAP_BITS(GAP)) u_dut (
    .Clk(Clk), .nRst(nRst), .InData(InData_a), .InValid(InValid_a),
    .InReady(InReady_a), .SoClk(SoClk_a), .SDout(SDout_a), .Busy(Busy_a),
    .FrameDone(FrameDone_a), .Level(Level_a)
  );

  serial_frame_tx #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH), .GAP_BITS(0)) u_gap0 (
    .Clk(Clk), .nRst(nRst), .InData(InData_b), .InValid(InValid_b),
    .InReady(InReady_b), .SoClk(SoClk_b), .SDout(SDout_b), .Busy(Busy_b),
    .FrameDone(FrameDone_b), .Level(Level_b)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: line is a stream of bit slots, one per SoClk period.
  int         n = 0;
  logic [7:0] mq[$];
  logic [1:0] bq[$];
  logic       m_sd = 0, m_fd = 0, m_lsb = 0, m_inframe = 0, m_sck = 0;

  always @(posedge Clk or negedge nRst) begin
    logic       acc;
    logic [1:0] e;
    logic [7:0] frame;
    if (!nRst) begin
      n = 0;
      mq.delete();
      bq.delete();
      m_sd = 0; m_fd = 0; m_lsb = 0; m_inframe = 0; m_sck = 0;
    end else begin
      acc = InValid_a && (mq.size() < DEPTH);
      n++;
      m_fd = 0;
      if (n % (2 * DIV) == 0) begin
        m_fd = m_lsb;
        if (bq.size() == 0 && mq.size() != 0) begin
          frame = mq.pop_front();
          bq.push_back(2'b01);
          for (int i = 7; i >= 0; i--) bq.push_back({i == 0, frame[i]});
          for (int g = 0; g < GAP; g++) bq.push_back(2'b00);
        end
        if (bq.size() != 0) begin
          e = bq.pop_front();
          m_sd = e[0]; m_lsb = e[1]; m_inframe = 1;
        end else begin
          m_sd = 0; m_lsb = 0; m_inframe = 0;
        end
      end
      m_sck = ((n / DIV) % 2) == 1;
      if (acc) mq.push_back(InData_a);
    end
  end

  int lvl_max = 0;
  int blocked = 0;
  int fd_a = 0;
  int fd_b = 0;

  always @(negedge Clk) begin
    if (chk_en) begin
      chk("SoClk", 32'(SoClk_a), 32'(m_sck));
      chk("SDout", 32'(SDout_a), 32'(m_sd));
      chk("FrameDone", 32'(FrameDone_a), 32'(m_fd));
      chk("Busy", 32'(Busy_a), 32'(m_inframe || mq.size() != 0));
      chk("Level", 32'(Level_a), 32'(mq.size()));
      chk("InReady", 32'(InReady_a), 32'(mq.size() != DEPTH));
    end
    if (int'(Level_a) > lvl_max) lvl_max = int'(Level_a);
    if (InValid_a && !InReady_a) blocked++;
    if (FrameDone_a) fd_a++;
    if (FrameDone_b) fd_b++;
  end

  // Loopback receiver and rise samplers
  logic       rise_a[$];
  logic       rise_b[$];
  logic [7:0] rx_q[$];
  logic       rx_act = 0;
  int         rx_k = 0;
  logic [7:0] rx_sh = 0;

  always @(posedge SoClk_a or negedge nRst) begin
    if (!nRst) begin
      rx_act = 0; rx_k = 0; rx_sh = 0;
    end else begin
      rise_a.push_back(SDout_a);
      if (!rx_act) begin
        if (SDout_a) begin rx_act = 1; rx_k = 0; end
      end else begin
        rx_sh = {rx_sh[6:0], SDout_a};
        rx_k++;
        if (rx_k == 8) begin rx_q.push_back(rx_sh); rx_act = 0; end
      end
    end
  end

  always @(posedge SoClk_b) rise_b.push_back(SDout_b);

  function automatic int first_one_a();
    for (int i = 0; i < rise_a.size(); i++) if (rise_a[i]) return i;
    return -1;
  endfunction

  function automatic int first_one_b();
    for (int i = 0; i < rise_b.size(); i++) if (rise_b[i]) return i;
    return -1;
  endfunction

  task automatic cyc(input int k);
    repeat (k) @(posedge Clk);
    #1;
  endtask

  task automatic push_a(input logic [7:0] b);
    logic rdy;
    logic ok;
    ok = 0;
    InData_a = b;
    InValid_a = 1;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge Clk);
      rdy = InReady_a;
      @(posedge Clk);
      #1;
      ok = rdy;
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL push_timeout: byte %0h not accepted, required accept within 400 cycles", b);
    end
  endtask

  task automatic push_b(input logic [7:0] b);
    logic rdy;
    logic ok;
    ok = 0;
    InData_b = b;
    InValid_b = 1;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge Clk);
      rdy = InReady_b;
      @(posedge Clk);
      #1;
      ok = rdy;
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL push_b_timeout: byte %0h not accepted, required accept within 400 cycles", b);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish by 200000");
    $fatal(1, "timeout");
  end

  initial begin
    logic [9:0]  v10;
    logic [18:0] v19;
    logic [7:0]  exp2[3];
    logic [7:0]  exp3[6];
    int st, fd_save, ok;

    exp2 = '{8'h00, 8'hFF, 8'h3C};
    exp3 = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};

    #1 nRst = 0;
    chk_en = 1;
    cyc(3);
    chk("rst_SDout", 32'(SDout_a), 0);
    chk("rst_SoClk", 32'(SoClk_a), 0);
    chk("rst_Level", 32'(Level_a), 0);
    chk("rst_InReady", 32'(InReady_a), 1);
    chk("rst_Busy", 32'(Busy_a), 0);
    chk("rst_FrameDone", 32'(FrameDone_a), 0);
    nRst = 1;
    cyc(3);

    // single 0xA5 frame
    rise_a.delete(); rx_q.delete(); fd_save = fd_a;
    push_a(8'hA5);
    InValid_a = 0;
    cyc(80);
    st = first_one_a();
    v10 = '0;
    if (st >= 0 && rise_a.size() >= st + 10)
      for (int i = 0; i < 10; i++) v10 = {v10[8:0], rise_a[st + i]};
    chk("a5_rise_bits", 32'(v10), 32'(10'b1101001010));
    chk("a5_framedone_cnt", 32'(fd_a - fd_save), 1);
    chk("a5_busy_after", 32'(Busy_a), 0);

    // loopback of three bytes
    rx_q.delete();
    push_a(8'h00); push_a(8'hFF); push_a(8'h3C);
    InValid_a = 0;
    cyc(180);
    chk("lb_count", 32'(rx_q.size()), 3);
    for (int i = 0; i < 3; i++)
      if (rx_q.size() > i) chk("lb_byte", 32'(rx_q[i]), 32'(exp2[i]));

    // six bytes with InValid held; FIFO fills and blocks
    rx_q.delete(); lvl_max = 0; blocked = 0;
    for (int i = 0; i < 6; i++) push_a(exp3[i]);
    InValid_a = 0;
    cyc(300);
    chk("full_level_max", 32'(lvl_max), 4);
    chk("full_blocked_seen", 32'(blocked > 0), 1);
    chk("full_count", 32'(rx_q.size()), 6);
    for (int i = 0; i < 6; i++)
      if (rx_q.size() > i) chk("full_byte", 32'(rx_q[i]), 32'(exp3[i]));

    // gapless instance: two back-to-back frames
    rise_b.delete(); fd_save = fd_b;
    push_b(8'hC3); push_b(8'h5A);
    InValid_b = 0;
    cyc(100);
    st = first_one_b();
    v19 = '0;
    if (st >= 0 && rise_b.size() >= st + 19)
      for (int i = 0; i < 19; i++) v19 = {v19[17:0], rise_b[st + i]};
    chk("gap0_rise_bits", 32'(v19), 32'({1'b1, 8'hC3, 1'b1, 8'h5A, 1'b0}));
    chk("gap0_framedone_cnt", 32'(fd_b - fd_save), 2);

    // reset during data bit 4 of 0x81
    rise_a.delete(); rx_q.delete();
    push_a(8'h81); push_a(8'h11); push_a(8'h22);
    InValid_a = 0;
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      st = first_one_a();
      if (st >= 0 && rise_a.size() >= st + 5) ok = 1;
      else cyc(1);
    end
    chk("rst6_reached_bit4", 32'(ok), 1);
    chk("rst6_level_before", 32'(Level_a), 2);
    fd_save = fd_a;
    nRst = 0;
    #1;
    chk("rst6_SDout", 32'(SDout_a), 0);
    chk("rst6_SoClk", 32'(SoClk_a), 0);
    chk("rst6_Level", 32'(Level_a), 0);
    chk("rst6_FrameDone", 32'(FrameDone_a), 0);
    cyc(3);
    nRst = 1;
    cyc(60);
    chk("rst6_no_framedone", 32'(fd_a - fd_save), 0);
    chk("rst6_no_rx", 32'(rx_q.size()), 0);
    push_a(8'h42);
    InValid_a = 0;
    cyc(80);
    chk("rst6_rx_count", 32'(rx_q.size()), 1);
    if (rx_q.size() > 0) chk("rst6_rx_byte", 32'(rx_q[0]), 32'h42);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
